// File: rtl/gbuf_pkg.sv
// gbuf_pkg: shared FSM states, default sizes and the byte-strobe merge helper for gbuf_dual_port.
package gbuf_pkg;
   typedef enum logic {GBUF_IDLE, GBUF_CLEAR} gbuf_state_e;
   localparam int GBUF_ADDR_BITS = 8;
   localparam int GBUF_DATA_BITS = 32;
   localparam int GBUF_MAX_BITS = 256;
   localparam int GBUF_MAX_LANES = GBUF_MAX_BITS / 8;
   function automatic logic [GBUF_MAX_BITS-1:0] gbuf_merge(input logic [GBUF_MAX_BITS-1:0] old_w,
                                                           input logic [GBUF_MAX_BITS-1:0] new_w,
                                                           input logic [GBUF_MAX_LANES-1:0] strb);
      logic [GBUF_MAX_BITS-1:0] m;
      m = old_w;
      for (int i = 0; i < GBUF_MAX_LANES; i++) m[i*8 +: 8] = strb[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
      return m;
   endfunction
endpackage

// File: rtl/gbuf_clear_seq.sv
// gbuf_clear_seq: sweeps every address once in ascending order to zero the buffer, then pulses clr_done.
module gbuf_clear_seq
   import gbuf_pkg::*;
#(
   parameter int ADDR_BITS = GBUF_ADDR_BITS,
   parameter int DEPTH = 2**ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_start,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic [ADDR_BITS-1:0] clr_addr,
   output logic                 clr_we
);
   gbuf_state_e state;
   logic last;
   assign last = clr_addr == ADDR_BITS'(DEPTH - 1);
   assign clr_we = clr_busy;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GBUF_IDLE;
         clr_addr <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         if (state == GBUF_IDLE) begin
            if (clr_start) begin
               state <= GBUF_CLEAR;
               clr_addr <= '0;
               clr_busy <= 1'b1;
            end
         end else if (last) begin
            state <= GBUF_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
         end else begin
            clr_addr <= clr_addr + 1'b1;
         end
      end
   end
endmodule

// File: rtl/gbuf_dual_port.sv
// gbuf_dual_port: byte-strobed dual-port buffer with write-first forwarding and a hardware clear.
// Define GBUF_PARITY_EN to store and check one even-parity bit per byte.
module gbuf_dual_port
   import gbuf_pkg::*;
#(
   parameter int ADDR_BITS = GBUF_ADDR_BITS,
   parameter int DATA_BITS = GBUF_DATA_BITS,
   parameter int DEPTH = 2**ADDR_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [ADDR_BITS-1:0]   wr_index,
   input  logic [DATA_BITS-1:0]   wr_data,
   input  logic [DATA_BITS/8-1:0] wr_strb,
   input  logic                   rd_en,
   input  logic [ADDR_BITS-1:0]   rd_index,
   output logic [DATA_BITS-1:0]   rd_data,
   output logic                   rd_valid,
   input  logic                   clr_start,
   output logic                   clr_busy,
   output logic                   clr_done,
   output logic                   wr_drop,
   output logic                   par_err
);
   localparam int NB = DATA_BITS / 8;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic                 clr_we;
   logic [ADDR_BITS-1:0] clr_addr;
   logic                 wr_ok;
   logic                 hit;
   logic [DATA_BITS-1:0] fwd;
   gbuf_clear_seq #(.ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH)) u_clr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_start(clr_start),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_addr (clr_addr),
      .clr_we   (clr_we)
   );
   assign wr_ok = wr_en & ~clr_busy;
   assign hit = wr_ok && (wr_index == rd_index);
   assign fwd = DATA_BITS'(gbuf_merge(GBUF_MAX_BITS'(mem[rd_index]), GBUF_MAX_BITS'(wr_data),
                                      GBUF_MAX_LANES'(wr_strb)));
`ifdef GBUF_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] rd_par;
   always_comb begin
      rd_par = '0;
      for (int i = 0; i < NB; i++) rd_par[i] = ^mem[rd_index][i*8 +: 8];
   end
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
         par_mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_strb[i]) begin
               mem[wr_index][i*8 +: 8] <= wr_data[i*8 +: 8];
               par_mem[wr_index][i] <= ^wr_data[i*8 +: 8];
            end
         end
      end
   end
   // Forwarded and clear-time reads never carry a stored-parity error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_err <= 1'b0;
      else par_err <= rd_en & ~clr_busy & ~hit & (|(rd_par ^ par_mem[rd_index]));
   end
`else
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NB; i++) if (wr_strb[i]) mem[wr_index][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
   end
   assign par_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_valid <= 1'b0;
         wr_drop <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         wr_drop <= wr_en & clr_busy;
         if (rd_en) rd_data <= clr_busy ? '0 : hit ? fwd : mem[rd_index];
      end
   end
endmodule

// File: tb/tb_gbuf_dual_port.sv
// tb_gbuf_dual_port: directed and randomized checks of gbuf_dual_port against a word-level buffer model.
module tb_gbuf_dual_port;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_index = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_index = '0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        clr_start = 1'b0;
   logic        clr_busy;
   logic        clr_done;
   logic        wr_drop;
   logic        par_err;

   gbuf_dual_port dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_index (wr_index),
      .wr_data  (wr_data),
      .wr_strb  (wr_strb),
      .rd_en    (rd_en),
      .rd_index (rd_index),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .clr_start(clr_start),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .wr_drop  (wr_drop),
      .par_err  (par_err)
   );

   always #5 clk = ~clk;

   logic [31:0] m [256];
   bit          known [256];
   int          clr_pos = -1;
   logic [31:0] exp_rd = '0;
   bit          exp_rd_known = 1'b1;
   int          par_bad = -1;
   int          compared = 0;
   int          mismatched = 0;
   int          busy_cnt;
   int          done_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   task automatic cyc(input bit we, input int wi, input logic [31:0] wd, input logic [3:0] ws,
                      input bit re, input int ri, input bit cs);
      bit busy, hit, edone, edrop, epar;
      busy = clr_pos >= 0;
      hit = we && !busy && wi == ri;
      wr_en = we; wr_index = 8'(wi); wr_data = wd; wr_strb = ws;
      rd_en = re; rd_index = 8'(ri); clr_start = cs;
      if (re) begin
         exp_rd = busy ? 32'h0 : hit ? mrg(m[ri], wd, ws) : m[ri];
         exp_rd_known = busy || (hit ? (known[ri] || ws == 4'hF) : known[ri]);
      end
      edone = busy && clr_pos == 255;
      edrop = we && busy;
      epar = re && !busy && !hit && ri == par_bad;
      @(posedge clk);
      #1;
      if (busy) begin
         m[clr_pos] = '0;
         known[clr_pos] = 1'b1;
         clr_pos = (clr_pos == 255) ? -1 : clr_pos + 1;
      end else begin
         if (we) begin
            known[wi] = known[wi] || ws == 4'hF;
            m[wi] = mrg(m[wi], wd, ws);
         end
         if (cs) clr_pos = 0;
      end
      chk("rd_valid", rd_valid, re);
      if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
      chk("clr_busy", clr_busy, clr_pos >= 0);
      chk("clr_done", clr_done, edone);
      chk("wr_drop", wr_drop, edrop);
      chk("par_err", par_err, epar);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_wr_drop", wr_drop, 0);
      chk("rst_par_err", par_err, 0);
      exp_rd = '0;
      exp_rd_known = 1'b1;
      clr_pos = -1;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      idle();
      // strobed write
      cyc(1, 5, 32'hAABBCCDD, 4'hF, 0, 0, 0);
      cyc(1, 5, 32'h11223344, 4'h5, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 5, 0);
      chk("strobe_word", rd_data, 32'hAA22CC44);
      idle();
      chk("hold_rd_data", rd_data, 32'hAA22CC44);
      // same-address collision returns write-first data
      cyc(1, 9, 32'h0, 4'hF, 0, 0, 0);
      cyc(1, 9, 32'hFFFFFFFF, 4'h3, 1, 9, 0);
      chk("collision_word", rd_data, 32'h0000FFFF);
      // full clear
      busy_cnt = 0; done_cnt = 0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      busy_cnt += int'(clr_busy);
      for (int i = 0; i < 256; i++) begin
         cyc(0, 0, 0, 0, 0, 0, (i == 20));
         busy_cnt += int'(clr_busy);
         done_cnt += int'(clr_done);
      end
      chk("clear_len", busy_cnt, 256);
      chk("clear_done_cnt", done_cnt, 1);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("clr_rd0", rd_data, 0);
      cyc(0, 0, 0, 0, 1, 128, 0);
      chk("clr_rd128", rd_data, 0);
      cyc(0, 0, 0, 0, 1, 255, 0);
      chk("clr_rd255", rd_data, 0);
      // write alongside clr_start, then a dropped write mid-clear
      cyc(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 1);
      for (int i = 0; i < 256; i++) begin
         cyc((i == 9), 3, 32'h1234, 4'hF, (i == 40), 3, 0);
         if (i == 9) chk("drop_pulse", wr_drop, 1);
      end
      cyc(0, 0, 0, 0, 1, 3, 0);
      chk("after_drop_rd3", rd_data, 0);
      // reset mid-clear
      cyc(1, 60, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      done_cnt = 0;
      for (int i = 0; i < 49; i++) begin
         cyc(0, 0, 0, 0, (i == 48), 60, 0);
         done_cnt += int'(clr_done);
      end
      chk("pre_rst_valid", rd_valid, 1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle();
         done_cnt += int'(clr_done);
      end
      chk("abort_no_done", done_cnt, 0);
      cyc(0, 0, 0, 0, 1, 60, 0);
      chk("abort_keeps_60", rd_data, 32'hCAFEF00D);
      busy_cnt = 0; done_cnt = 0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      busy_cnt += int'(clr_busy);
      for (int i = 0; i < 256; i++) begin
         idle();
         busy_cnt += int'(clr_busy);
         done_cnt += int'(clr_done);
      end
      chk("reclear_len", busy_cnt, 256);
      chk("reclear_done_cnt", done_cnt, 1);
`ifdef GBUF_PARITY_EN
      cyc(1, 7, 32'h0F0F0F0F, 4'hF, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 7, 0);
      chk("par_clean", par_err, 0);
      dut.mem[7][0] = ~dut.mem[7][0];
      m[7][0] = ~m[7][0];
      par_bad = 7;
      cyc(0, 0, 0, 0, 1, 7, 0);
      chk("par_flip", par_err, 1);
      cyc(0, 0, 0, 0, 1, 8, 0);
      cyc(1, 7, 32'h0F0F0F0F, 4'hF, 0, 0, 0);
      par_bad = -1;
`endif
      for (int i = 0; i < 900; i++) begin
         int wi, ri;
         wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
         ri = ($urandom_range(0, 2) == 0) ? wi : int'($urandom_range(0, 15));
         cyc(bit'($urandom_range(0, 1)), wi, $urandom, 4'($urandom_range(0, 15)),
             bit'($urandom_range(0, 1)), ri, ($urandom_range(0, 199) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/gbuf_dual_port.md
GBUF_DUAL_PORT -- requirements
Module: gbuf_dual_port

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning word address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, meaning word width; must be a multiple of 8.
REQ-003 SHALL have derived parameter DEPTH, default 2**ADDR_BITS, meaning word count.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en, input, 1 bit: write request.
REQ-007 SHALL have port wr_index, input, ADDR_BITS bits: write address.
REQ-008 SHALL have port wr_data, input, DATA_BITS bits: write data.
REQ-009 SHALL have port wr_strb, input, DATA_BITS/8 bits: byte-lane write enables.
REQ-010 SHALL have port rd_en, input, 1 bit: read request.
REQ-011 SHALL have port rd_index, input, ADDR_BITS bits: read address.
REQ-012 SHALL have port rd_data, output, DATA_BITS bits: registered read data.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data updated this cycle.
REQ-014 SHALL have port clr_start, input, 1 bit: start the hardware clear.
REQ-015 SHALL have port clr_busy, output, 1 bit: clear in progress.
REQ-016 SHALL have port clr_done, output, 1 bit: one-cycle pulse at clear end.
REQ-017 SHALL have port wr_drop, output, 1 bit: one-cycle pulse when a write is discarded.
REQ-018 SHALL have port par_err, output, 1 bit: parity mismatch on the current read.

Function
REQ-019 SHALL implement independent read and write ports, both usable in the same cycle.
REQ-020 SHALL, for a write (wr_en=1, FSM IDLE), update only the bytes of wr_index whose wr_strb bit is 1; other bytes keep their values.
REQ-021 SHALL give a read 1-cycle latency: rd_en at edge N makes rd_data=mem[rd_index] and rd_valid=1 after edge N.
REQ-022 SHALL keep rd_data unchanged and drive rd_valid=0 in any cycle following rd_en=0.
REQ-023 SHALL, when a read and a write hit the same address in one cycle, return write-first data: the strobe-merged new word.
REQ-024 SHALL use FSM states IDLE and CLEAR.
REQ-025 SHALL move IDLE->CLEAR on clr_start=1; clr_start in CLEAR is ignored.
REQ-026 SHALL, in CLEAR, write zero to one address per cycle, from 0 to DEPTH-1 in ascending order, with clr_busy=1 throughout.
REQ-027 SHALL, after writing address DEPTH-1, return to IDLE and pulse clr_done for one cycle; clear duration is exactly DEPTH cycles.
REQ-028 SHALL, in CLEAR, discard external writes and pulse wr_drop in the cycle after each discarded write.
REQ-029 SHALL, in CLEAR, still accept reads, returning 0 with rd_valid=1.
REQ-030 SHALL let a write issued in the same cycle as clr_start complete normally; that address is then zeroed by the clear.
REQ-031 SHALL wrap neither address counter; the clear counter stops at DEPTH-1.

Reset
REQ-032 SHALL, on rst_n=0, immediately force: FSM=IDLE, clear counter=0, rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, wr_drop=0, par_err=0.
REQ-033 SHALL NOT reset array contents (contents undefined until a clear or a write); this allows RAM inference.
REQ-034 SHALL, on reset during CLEAR, abort the clear without a clr_done pulse.

Configuration
REQ-035 SHALL, when GBUF_PARITY_EN is defined, store one even-parity bit per byte on every write and every clear write (a clear writes parity 0).
REQ-036 SHALL, with GBUF_PARITY_EN, assert par_err with rd_valid when any byte of the read word fails its parity check; forwarded write-first data computes parity fresh and never errors.
REQ-037 SHALL, without GBUF_PARITY_EN, omit parity storage and tie par_err to 0; the port list is identical in both builds.

Structure
REQ-038 SHALL take from shared package gbuf_pkg: the FSM state enum (GBUF_IDLE, GBUF_CLEAR), default parameter constants, and a strobe-merge function (old, new, strb) -> word.
REQ-039 SHALL place the clear FSM and counter in sub-module gbuf_clear_seq, with outputs clr_busy, clr_done, clr_addr, clr_we.
REQ-040 SHALL keep the memory array and the read/write datapath in gbuf_dual_port.

Verification
REQ-041 SHALL cover a strobed write: write 0xAABBCCDD to addr 5 with strb=1111, then 0x11223344 with strb=0101, then read addr 5 -> rd_data=0xAA22CC44 one cycle later, rd_valid=1.
REQ-042 SHALL cover a same-address collision: word 0x0 at addr 9; same cycle write 0xFFFFFFFF strb=0011 and read addr 9 -> rd_data=0x0000FFFF.
REQ-043 SHALL cover clear: DEPTH=256; pulse clr_start -> clr_busy high 256 cycles, clr_done pulses once at the end; reads of addr 0, 128 and 255 then return 0.
REQ-044 SHALL cover a write during clear: write 0x1234 to addr 3 at cycle 10 of the clear -> wr_drop pulses; after clr_done, read addr 3 -> 0.
REQ-045 SHALL cover reset mid-clear: assert rst_n=0 at clear cycle 50 -> clr_busy=0 and rd_valid=0 immediately; no clr_done; a new clr_start then runs the full 256 cycles.
REQ-046 SHALL cover parity (GBUF_PARITY_EN build): force-flip stored bit 0 of addr 7 via a backdoor, then read addr 7 -> par_err=1 with rd_valid; a clean read -> par_err=0.
